wb_regfile: RTL and testbench

- Write-back stage plus architectural register file. Consumes the MEM/WB pipeline-latch outputs and selects the write-back value. Commits it to a 32-entry register file.
- Serves the two ID-stage read ports with write-first internal bypass.
- Exports the committed write (value, destination, enable) for the forwarding unit, plus a retired-write counter for debug.

---
 rtl/wb_regfile_pkg.sv | 18 +
 rtl/wb_regfile_2r1w.sv | 44 ++++
 rtl/wb_regfile.sv | 112 +++++++++++
 tb/tb_wb_regfile.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back stage and architectural register file.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// The default widths mirror the machine word and register-address formats used
// by the rest of the pipeline: WORD is [31:0] and REGADDR is [4:0].
// Register zero is address 0.
package wb_regfile_pkg;

    localparam int unsigned WB_NUM_REGS = 32;  // architectural registers
    localparam int unsigned WB_ADDR_W   = 5;   // log2(WB_NUM_REGS)
    localparam int unsigned WB_DATA_W   = 32;  // machine word
    localparam int unsigned WB_CNT_W    = 32;  // retired-write counter width

    // Register zero; compared zero-extended so it works at any address width.
    localparam logic [WB_ADDR_W-1:0] WB_REG_ZERO = '0;

endpackage

// File: rtl/wb_regfile_2r1w.sv
// Plain 2-read/1-write storage array, cleared by synchronous reset.
// Latency: writes land on the next rising edge; reads are combinational.
// Backpressure: none; a write is accepted on every edge where we_i is high.
//
// Ports:
//   clk_i, rst_i             clock and synchronous active-high clear
//   we_i, waddr_i, wdata_i   write port
//   raddr_a_i / rdata_a_o    read port A
//   raddr_b_i / rdata_b_o    read port B
// No bypass and no register-zero handling here; the wrapper owns both.
module regfile_2r1w
    import wb_regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = WB_NUM_REGS,
    parameter int unsigned ADDR_W   = WB_ADDR_W,
    parameter int unsigned DATA_W   = WB_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value, commits it to the register
// file, serves two ID read ports with write-first bypass, counts retired writes.
// Latency: commit on the next rising edge; bypass makes it readable in the same cycle.
// Backpressure: none; every valid write-back is committed unconditionally.
//
// Ports:
//   CLK_i, RST_i                       clock, synchronous active-high reset
//   memToReg_i, regWrite_i             MEM/WB control (mem-vs-ALU select, write enable)
//   wbDato_i, aluOut_i, regDest_i      MEM/WB data and destination
//   rsAddr_i/rsData_o, rtAddr_i/rtData_o   ID read ports
//   wbValue_o, wbDest_o, wbEn_o        committed write, exported to forwarding
//   retireCnt_o                        count of committed writes (wraps)
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = WB_NUM_REGS,
    parameter int unsigned ADDR_W   = WB_ADDR_W,
    parameter int unsigned DATA_W   = WB_DATA_W,
    parameter int unsigned CNT_W    = WB_CNT_W
) (
    input  logic              CLK_i,
    input  logic              RST_i,
    input  logic              memToReg_i,
    input  logic              regWrite_i,
    input  logic [DATA_W-1:0] wbDato_i,
    input  logic [DATA_W-1:0] aluOut_i,
    input  logic [ADDR_W-1:0] regDest_i,
    input  logic [ADDR_W-1:0] rsAddr_i,
    input  logic [ADDR_W-1:0] rtAddr_i,
    output logic [DATA_W-1:0] rsData_o,
    output logic [DATA_W-1:0] rtData_o,
    output logic [DATA_W-1:0] wbValue_o,
    output logic [ADDR_W-1:0] wbDest_o,
    output logic              wbEn_o,
    output logic [CNT_W-1:0]  retireCnt_o
);

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    logic [DATA_W-1:0] wb_value;
    logic              wb_en;
    logic [DATA_W-1:0] rf_rs_dat;
    logic [DATA_W-1:0] rf_rt_dat;
    logic [CNT_W-1:0]  retire_cnt_q;
    logic [CNT_W-1:0]  retire_cnt_d;

    // Write-back select and effective enable. Gating on regWrite_i first means
    // an unknown memToReg_i on an idle cycle cannot reach the array or counter.
    assign wb_value = memToReg_i ? wbDato_i : aluOut_i;
    assign wb_en    = regWrite_i && (regDest_i != REG_ZERO);

    assign wbValue_o = wb_value;
    assign wbDest_o  = regDest_i;
    assign wbEn_o    = wb_en;

    // Array entry 0 is never written because wb_en excludes it, so the storage
    // stays architecturally clean even before the read-side mask below.
    regfile_2r1w #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) u_rf (
        .clk_i     (CLK_i),
        .rst_i     (RST_i),
        .we_i      (wb_en),
        .waddr_i   (regDest_i),
        .wdata_i   (wb_value),
        .raddr_a_i (rsAddr_i),
        .rdata_a_o (rf_rs_dat),
        .raddr_b_i (rtAddr_i),
        .rdata_b_o (rf_rt_dat)
    );

    // Read path: r0 mask has priority, then write-first bypass, then the array.
    // Both ports use the same rule, so equal addresses always give equal data.
    always_comb begin
        rsData_o = rf_rs_dat;
        if (rsAddr_i == REG_ZERO) begin
            rsData_o = '0;
        end else if (wb_en && (rsAddr_i == regDest_i)) begin
            rsData_o = wb_value;
        end
    end

    always_comb begin
        rtData_o = rf_rt_dat;
        if (rtAddr_i == REG_ZERO) begin
            rtData_o = '0;
        end else if (wb_en && (rtAddr_i == regDest_i)) begin
            rtData_o = wb_value;
        end
    end

    // Retired-write counter; wraps naturally at 2^CNT_W.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (wb_en) begin
            retire_cnt_d = retire_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retireCnt_o = retire_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile (counter narrowed to 4 bits).
// Latency: inputs change 1ns after a rising edge; outputs sampled 1ns later.
// Backpressure: n/a.
module tb_wb_regfile;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              mem_to_reg;
    logic              reg_write;
    logic [DATA_W-1:0] wb_dato;
    logic [DATA_W-1:0] alu_out;
    logic [ADDR_W-1:0] reg_dest;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] wb_value;
    logic [ADDR_W-1:0] wb_dest;
    logic              wb_en;
    logic [CNT_W-1:0]  retire_cnt;

    int n_checks;
    int n_fail;
    logic [CNT_W-1:0] exp_cnt;

    wb_regfile #(
        .NUM_REGS (32),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .CNT_W    (CNT_W)
    ) dut (
        .CLK_i       (clk),
        .RST_i       (rst),
        .memToReg_i  (mem_to_reg),
        .regWrite_i  (reg_write),
        .wbDato_i    (wb_dato),
        .aluOut_i    (alu_out),
        .regDest_i   (reg_dest),
        .rsAddr_i    (rs_addr),
        .rtAddr_i    (rt_addr),
        .rsData_o    (rs_data),
        .rtData_o    (rt_data),
        .wbValue_o   (wb_value),
        .wbDest_o    (wb_dest),
        .wbEn_o      (wb_en),
        .retireCnt_o (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and leave inputs changeable 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        reg_write = 1'b0;
        step();
        rst = 1'b0;
        exp_cnt = '0;
        for (int a = 0; a < 32; a++) begin
            rs_addr = ADDR_W'(a);
            rt_addr = ADDR_W'(31 - a);
            #1;
            n_checks++;
            if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read a=%0d rs=%h rt=%h required 0", a, rs_data, rt_data);
            end
        end
        n_checks++;
        if (retire_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_cnt got %0d required 0", retire_cnt);
        end
    endtask

    task automatic test_alu_wb();
        reg_write = 1'b1; mem_to_reg = 1'b0;
        alu_out = 32'hDEADBEEF; wb_dato = 32'h12345678; reg_dest = 5'd5;
        rs_addr = 5'd1; rt_addr = 5'd2;
        #1;
        n_checks++;
        if (wb_value !== 32'hDEADBEEF || wb_en !== 1'b1 || wb_dest !== 5'd5) begin
            n_fail++;
            $display("FAIL alu_sel val=%h en=%b dest=%0d required DEADBEEF 1 5", wb_value, wb_en, wb_dest);
        end
        step();
        exp_cnt = exp_cnt + 1'b1;
        reg_write = 1'b0; rs_addr = 5'd5;
        #1;
        n_checks++;
        if (rs_data !== 32'hDEADBEEF || retire_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL alu_commit r5=%h cnt=%0d required DEADBEEF %0d", rs_data, retire_cnt, exp_cnt);
        end
    endtask

    task automatic test_mem_bypass();
        reg_write = 1'b1; mem_to_reg = 1'b1;
        wb_dato = 32'hCAFE0001; alu_out = 32'h0BAD0BAD; reg_dest = 5'd7;
        rs_addr = 5'd7; rt_addr = 5'd7;
        #1;
        n_checks++;
        if (rs_data !== 32'hCAFE0001 || rt_data !== 32'hCAFE0001 || wb_value !== 32'hCAFE0001) begin
            n_fail++;
            $display("FAIL mem_bypass rs=%h rt=%h val=%h required CAFE0001", rs_data, rt_data, wb_value);
        end
        step();
        exp_cnt = exp_cnt + 1'b1;
        reg_write = 1'b0;
        #1;
        n_checks++;
        if (rs_data !== 32'hCAFE0001 || rt_data !== 32'hCAFE0001 || retire_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL mem_commit rs=%h rt=%h cnt=%0d required CAFE0001 %0d", rs_data, rt_data, retire_cnt, exp_cnt);
        end
    endtask

    // Overwrite r5: bypass must show the new value over the stale array entry,
    // while the other port (no match) keeps reading the array.
    task automatic test_bypass_stale();
        reg_write = 1'b1; mem_to_reg = 1'b0;
        alu_out = 32'hA5A5A5A5; reg_dest = 5'd5;
        rs_addr = 5'd5; rt_addr = 5'd7;
        #1;
        n_checks++;
        if (rs_data !== 32'hA5A5A5A5 || rt_data !== 32'hCAFE0001) begin
            n_fail++;
            $display("FAIL bypass_stale rs=%h rt=%h required A5A5A5A5 CAFE0001", rs_data, rt_data);
        end
        reg_write = 1'b0;
        #1;
        n_checks++;
        if (rs_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL no_bypass_idle rs=%h required DEADBEEF", rs_data);
        end
        reg_write = 1'b1;
        step();
        exp_cnt = exp_cnt + 1'b1;
        reg_write = 1'b0;
        #1;
        n_checks++;
        if (rs_data !== 32'hA5A5A5A5 || retire_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL overwrite r5=%h cnt=%0d required A5A5A5A5 %0d", rs_data, retire_cnt, exp_cnt);
        end
    endtask

    task automatic test_r0();
        reg_write = 1'b1; mem_to_reg = 1'b0;
        alu_out = 32'hFFFFFFFF; reg_dest = 5'd0;
        rs_addr = 5'd0; rt_addr = 5'd0;
        #1;
        n_checks++;
        if (wb_en !== 1'b0 || rs_data !== 32'h0 || rt_data !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_pre en=%b rs=%h rt=%h required 0 0 0", wb_en, rs_data, rt_data);
        end
        step();
        reg_write = 1'b0;
        #1;
        n_checks++;
        if (rs_data !== 32'h0 || retire_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL r0_post rs=%h cnt=%0d required 0 %0d", rs_data, retire_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_collision();
        rst = 1'b1;
        reg_write = 1'b1; mem_to_reg = 1'b0;
        alu_out = 32'h55AA55AA; reg_dest = 5'd9;
        step();
        rst = 1'b0; reg_write = 1'b0;
        exp_cnt = '0;
        rs_addr = 5'd9; rt_addr = 5'd5;
        #1;
        n_checks++;
        if (rs_data !== 32'h0 || rt_data !== 32'h0 || retire_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_wins r9=%h r5=%h cnt=%0d required 0 0 0", rs_data, rt_data, retire_cnt);
        end
    endtask

    task automatic test_idle_x_select();
        reg_write = 1'b0; mem_to_reg = 1'bx;
        wb_dato = 32'h01010101; alu_out = 32'h02020202; reg_dest = 5'd3;
        rs_addr = 5'd3;
        step();
        mem_to_reg = 1'b0;
        #1;
        n_checks++;
        if (rs_data !== 32'h0 || retire_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL idle_x r3=%h cnt=%0d required 0 %0d", rs_data, retire_cnt, exp_cnt);
        end
    endtask

    // 17 writes: counter must read 1..15, 0, 1.
    task automatic test_counter_wrap();
        mem_to_reg = 1'b0;
        for (int i = 0; i < 17; i++) begin
            reg_write = 1'b1;
            reg_dest = ADDR_W'(1 + (i % 31));
            alu_out = 32'h1000 + i;
            step();
            exp_cnt = 4'((i + 1) % 16);
            n_checks++;
            if (retire_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL cnt_wrap write=%0d cnt=%0d required %0d", i + 1, retire_cnt, exp_cnt);
            end
        end
        reg_write = 1'b0;
        rs_addr = 5'd17; rt_addr = 5'd1;
        #1;
        n_checks++;
        if (rs_data !== 32'h1010 || rt_data !== 32'h1000) begin
            n_fail++;
            $display("FAIL wrap_data r17=%h r1=%h required 00001010 00001000", rs_data, rt_data);
        end
    endtask

    task automatic test_back_to_back();
        reg_write = 1'b1; mem_to_reg = 1'b1;
        wb_dato = 32'h0000AAAA; reg_dest = 5'd10;
        step();
        wb_dato = 32'h0000BBBB; reg_dest = 5'd11;
        rs_addr = 5'd10; rt_addr = 5'd11;
        #1;
        n_checks++;
        if (rs_data !== 32'h0000AAAA || rt_data !== 32'h0000BBBB) begin
            n_fail++;
            $display("FAIL b2b_pre r10=%h r11=%h required 0000AAAA 0000BBBB", rs_data, rt_data);
        end
        step();
        exp_cnt = exp_cnt + 4'd2;
        reg_write = 1'b0;
        #1;
        n_checks++;
        if (rs_data !== 32'h0000AAAA || rt_data !== 32'h0000BBBB || retire_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL b2b_post r10=%h r11=%h cnt=%0d required 0000AAAA 0000BBBB %0d",
                     rs_data, rt_data, retire_cnt, exp_cnt);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        exp_cnt = '0;
        rst = 1'b0;
        mem_to_reg = 1'b0;
        reg_write = 1'b0;
        wb_dato = '0;
        alu_out = '0;
        reg_dest = '0;
        rs_addr = '0;
        rt_addr = '0;
        #2;
        test_reset();
        test_alu_wb();
        test_mem_bypass();
        test_bypass_stale();
        test_r0();
        test_reset_collision();
        test_idle_x_select();
        test_counter_wrap();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
